// File: rtl/imem_pkg.sv
// Shared types and boot image for the MIPS instruction memory.
package imem_pkg;

    localparam int unsigned INSTR_W  = 32;
    localparam int unsigned BOOT_LEN = 4;

    typedef logic [INSTR_W-1:0] instr_t;

    localparam instr_t IMEM_NOP = 32'h0000_0000;

    // addi $t0,5 / addi $t1,10 / add $t2,$t0,$t1 / sw $t2,0($zero)
    localparam instr_t BOOT_PROG [BOOT_LEN] = '{
        32'h2008_0005,
        32'h2009_000A,
        32'h0109_5020,
        32'hAC0A_0000
    };

    // Boot image word at a given index; words past the program read as zero.
    function automatic instr_t boot_word(input int unsigned idx);
        instr_t w;
        w = IMEM_NOP;
        for (int unsigned i = 0; i < BOOT_LEN; i++) begin
            if (idx == i) begin
                w = BOOT_PROG[i];
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/imem_array.sv
// Instruction word storage: constant boot ROM, or a writable array seeded
// with the boot image when IMEM_LOAD_EN is defined.
module imem_array
    import imem_pkg::*;
#(
    parameter int unsigned DEPTH = 256,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
`ifdef IMEM_LOAD_EN
    input  logic          clk,
    input  logic          ld_we,
    input  logic [AW-1:0] ld_addr,
    input  instr_t        ld_data,
`endif
    input  logic [AW-1:0] rd_addr,
    output instr_t        rd_data_c
);

`ifdef IMEM_LOAD_EN
    instr_t words [DEPTH];

    // One register per word, seeded with the boot image and untouched by reset.
    for (genvar i = 0; i < DEPTH; i++) begin : g_word
        instr_t word_q = boot_word(32'(i));

        always_ff @(posedge clk) begin
            if (ld_we && (ld_addr == AW'(i))) begin
                word_q <= ld_data;
            end
        end

        assign words[i] = word_q;
    end

    // Combinational read: a same-edge write is seen only by later fetches.
    assign rd_data_c = words[rd_addr];
`else
    assign rd_data_c = boot_word(32'(rd_addr));
`endif

endmodule

// File: rtl/mips_imem.sv
// IF-stage instruction memory: address check, one-cycle registered fetch.
// Optional program-load port enabled by defining IMEM_LOAD_EN.
module mips_imem
    import imem_pkg::*;
#(
    parameter int unsigned DEPTH = 256,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic [31:0]   pc_addr,
`ifdef IMEM_LOAD_EN
    input  logic          ld_we,
    input  logic [AW-1:0] ld_addr,
    input  logic [31:0]   ld_data,
`endif
    output logic [31:0]   instr,
    output logic          instr_valid,
    output logic          addr_err
);

    if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("mips_imem: DEPTH must be a power of two and at least 4");
    end

    logic [AW-1:0] word_idx_c;
    logic          legal_c;
    instr_t        rd_data_c;

    assign word_idx_c = pc_addr[AW+1:2];
    assign legal_c    = (pc_addr[1:0] == 2'b00) && ((pc_addr >> (AW + 2)) == 32'd0);

    imem_array #(
        .DEPTH (DEPTH)
    ) u_array (
`ifdef IMEM_LOAD_EN
        .clk       (clk),
        .ld_we     (ld_we),
        .ld_addr   (ld_addr),
        .ld_data   (instr_t'(ld_data)),
`endif
        .rd_addr   (word_idx_c),
        .rd_data_c (rd_data_c)
    );

    // IF/ID output register; a stall holds everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr       <= IMEM_NOP;
            instr_valid <= 1'b0;
            addr_err    <= 1'b0;
        end else if (en) begin
            instr_valid <= 1'b1;
            if (legal_c) begin
                instr    <= rd_data_c;
                addr_err <= 1'b0;
            end else begin
                instr    <= IMEM_NOP;
                addr_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mips_imem.sv
// Directed table-driven bench for mips_imem (default DEPTH=256).
module tb_mips_imem;

    localparam int unsigned DEPTH = 256;
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned NVEC  = 17;

    typedef struct {
        logic        en;
        logic [31:0] pc;
        logic [31:0] exp_instr;
        logic        exp_valid;
        logic        exp_err;
    } vec_t;

    logic          clk;
    logic          rst_n;
    logic          en;
    logic [31:0]   pc_addr;
    logic [31:0]   instr;
    logic          instr_valid;
    logic          addr_err;
`ifdef IMEM_LOAD_EN
    logic          ld_we;
    logic [AW-1:0] ld_addr;
    logic [31:0]   ld_data;
`endif

    int total;
    int bad;
    vec_t vecs [NVEC];

    mips_imem #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .pc_addr     (pc_addr),
`ifdef IMEM_LOAD_EN
        .ld_we       (ld_we),
        .ld_addr     (ld_addr),
        .ld_data     (ld_data),
`endif
        .instr       (instr),
        .instr_valid (instr_valid),
        .addr_err    (addr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] exp_i,
                         input logic exp_v, input logic exp_e);
        total++;
        if (instr !== exp_i || instr_valid !== exp_v || addr_err !== exp_e) begin
            bad++;
            $display("FAIL %s: got instr=%08h valid=%0b err=%0b, want instr=%08h valid=%0b err=%0b",
                     name, instr, instr_valid, addr_err, exp_i, exp_v, exp_e);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;

        vecs[0]  = '{1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 32'h0000_0000, 32'h2008_0005, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, 32'h0000_0004, 32'h2009_000A, 1'b1, 1'b0};
        vecs[3]  = '{1'b1, 32'h0000_0008, 32'h0109_5020, 1'b1, 1'b0};
        vecs[4]  = '{1'b1, 32'h0000_000C, 32'hAC0A_0000, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b1};
        vecs[6]  = '{1'b1, 32'h0000_0004, 32'h2009_000A, 1'b1, 1'b0};
        vecs[7]  = '{1'b1, 32'h0000_0002, 32'h0000_0000, 1'b1, 1'b1};
        vecs[8]  = '{1'b1, 32'h0000_0003, 32'h0000_0000, 1'b1, 1'b1};
        vecs[9]  = '{1'b1, 32'h0000_000C, 32'hAC0A_0000, 1'b1, 1'b0};
        vecs[10] = '{1'b1, 32'h0000_0400, 32'h0000_0000, 1'b1, 1'b1};
        vecs[11] = '{1'b1, 32'hFFFF_FFFC, 32'h0000_0000, 1'b1, 1'b1};
        vecs[12] = '{1'b1, 32'h0000_0008, 32'h0109_5020, 1'b1, 1'b0};
        // stall for three cycles while the address moves
        vecs[13] = '{1'b0, 32'h0000_0004, 32'h0109_5020, 1'b1, 1'b0};
        vecs[14] = '{1'b0, 32'h0000_0001, 32'h0109_5020, 1'b1, 1'b0};
        vecs[15] = '{1'b0, 32'h0000_0400, 32'h0109_5020, 1'b1, 1'b0};
        vecs[16] = '{1'b1, 32'h0000_0004, 32'h2009_000A, 1'b1, 1'b0};

        rst_n   = 1'b0;
        en      = 1'b0;
        pc_addr = 32'h0;
`ifdef IMEM_LOAD_EN
        ld_we   = 1'b0;
        ld_addr = '0;
        ld_data = 32'h0;
`endif
        repeat (2) @(posedge clk);
        #1 check("reset", 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            en      = vecs[i].en;
            pc_addr = vecs[i].pc;
            @(posedge clk);
            #1 check($sformatf("vec%0d", i), vecs[i].exp_instr,
                     vecs[i].exp_valid, vecs[i].exp_err);
        end

        // Top-of-range word: legal, reads zero.
        @(negedge clk);
        en = 1'b1; pc_addr = 32'h0000_03FC;
        @(posedge clk);
        #1 check("top_word", 32'h0, 1'b1, 1'b0);

        // Leave an error flagged, then reset between edges.
        @(negedge clk);
        pc_addr = 32'h0000_0003;
        @(posedge clk);
        #1 check("pre_reset_err", 32'h0, 1'b1, 1'b1);
        @(negedge clk);
        pc_addr = 32'h0000_0004;
        @(posedge clk);
        #1 check("pre_reset_word", 32'h2009_000A, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1 check("async_reset", 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1; pc_addr = 32'h0;
        @(posedge clk);
        #1 check("post_reset_fetch", 32'h2008_0005, 1'b1, 1'b0);

`ifdef IMEM_LOAD_EN
        // Same-cycle write and read of word 2 returns the old word.
        @(negedge clk);
        ld_we = 1'b1; ld_addr = AW'(2); ld_data = 32'hDEAD_BEEF;
        en = 1'b1; pc_addr = 32'h8;
        @(posedge clk);
        #1 check("load_old_data", 32'h0109_5020, 1'b1, 1'b0);
        @(negedge clk);
        ld_we = 1'b0;
        @(posedge clk);
        #1 check("load_new_data", 32'hDEAD_BEEF, 1'b1, 1'b0);
        // Write during stall still lands.
        @(negedge clk);
        en = 1'b0; ld_we = 1'b1; ld_addr = AW'(3); ld_data = 32'h1234_5678;
        @(posedge clk);
        #1 check("load_stall_hold", 32'hDEAD_BEEF, 1'b1, 1'b0);
        @(negedge clk);
        ld_we = 1'b0; en = 1'b1; pc_addr = 32'hC;
        @(posedge clk);
        #1 check("load_during_stall", 32'h1234_5678, 1'b1, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mips_imem.md
# mips_imem

Instruction memory for the pipelined MIPS core, feeding the IF stage. Takes the byte-addressed PC, reads one 32-bit word from an internal word array, and presents it to the IF/ID boundary one clock later. A built-in boot program occupies the array at start-up. Illegal fetch addresses return a NOP and raise an error flag.

## Interface
- `DEPTH`, default 256: number of 32-bit words. Must be a power of two, ≥ 4.
- `AW`, default $clog2(DEPTH): word-index width. This is a derived localparam.
- `clk` (in, 1): sole clock; every register updates on the rising edge.
- `rst_n` (in, 1): asynchronous, active-low reset.
- `en` (in, 1): fetch enable. Low means stall: outputs hold.
- `pc_addr` (in, 32): byte address of the instruction to fetch.
- `instr` (out, 32): fetched instruction word.
- `instr_valid` (out, 1): `instr` holds a completed fetch.
- `addr_err` (out, 1): the last fetch was misaligned or out of range.
- `ld_we` (in, 1), `ld_addr` (in, AW), `ld_data` (in, 32): program-load write port. These ports exist only with IMEM_LOAD_EN.

## Operation
- Word index = `pc_addr[AW+1:2]`.
- A fetch is legal when `pc_addr[1:0]` == 0 and `pc_addr[31:AW+2]` == 0.
- Legal fetch: `instr` ← mem[index], `addr_err` ← 0.
- Illegal fetch: `instr` ← NOP (32'h0000_0000), `addr_err` ← 1. Memory is not accessed.
- `instr_valid` ← 1 on every cycle with `en` = 1.
- `en` = 0: `instr`, `addr_err` and `instr_valid` all hold their values.
- Memory contents at time zero come from the boot program constant. All words beyond the program are 0.
- Reset never alters memory contents.

## Timing
- Reset, asynchronous: `instr` = 0, `instr_valid` = 0, `addr_err` = 0.
- First fetch completes on the first rising edge with `rst_n` = 1 and `en` = 1.
- Latency: 1 cycle. `pc_addr` is sampled at edge N and the result is visible after edge N.
- `pc_addr` may change every cycle. Throughput is one word per cycle.
- Load write, when enabled: mem[`ld_addr`] ← `ld_data` at the edge when `ld_we` = 1.
- Read and write to the same word in one cycle: the fetch returns the old data. The new data is visible from the next fetch on.
- A load write proceeds regardless of `en`.
- Reset asserted mid-stream: outputs clear immediately. The first fetch after release restarts cleanly.

## Configuration
- `IMEM_LOAD_EN` defined: `ld_we`, `ld_addr` and `ld_data` exist. The array is writable and still initialised with the boot program.
- Not defined: the load ports are absent and the array is a constant ROM holding the boot program.

## Structure
- Package `imem_pkg` holds the following:
  - `IMEM_NOP` = 32'h0000_0000.
  - Boot program constant array:
    - word0 = 32'h2008_0005 (addi $t0,$zero,5)
    - word1 = 32'h2009_000A (addi $t1,$zero,10)
    - word2 = 32'h0109_5020 (add $t2,$t0,$t1)
    - word3 = 32'hAC0A_0000 (sw $t2,0($zero))
  - Typedef `instr_t` (32-bit).
- One sub-module, `imem_array`: the word storage plus optional write port. The top holds address checking and the output registers.

## Test plan
- Reset then `en` = 1 with `pc_addr` = 0, 4, 8, 12 on successive cycles → `instr` = 2008_0005, 2009_000A, 0109_5020, AC0A_0000, each one cycle after its address, with `addr_err` = 0.
- `pc_addr` = 1, 2 or 3 → `instr` = 0, `addr_err` = 1, `instr_valid` = 1.
- `pc_addr` = DEPTH*4 (0x400) or 0xFFFF_FFFC → `instr` = 0, `addr_err` = 1. `pc_addr` = 0x3FC → `instr` = 0, `addr_err` = 0.
- Stall: hold `en` = 0 for 3 cycles while `pc_addr` changes → outputs frozen; `en` back to 1 → the new address is fetched next edge.
- Assert `rst_n` = 0 mid-stream between edges → `instr`, `instr_valid` and `addr_err` go to 0 at once. After release, fetch of 0 → 2008_0005.
- With IMEM_LOAD_EN: write 32'hDEAD_BEEF to word 2 while fetching `pc_addr` = 8 in the same cycle → 0109_5020 is returned. The next fetch of 8 → DEAD_BEEF.
